// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide,
// plus the MFHI/MFLO/MTHI/MTLO accessors and the EX-stage stall request.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             opValid,
   input  logic [5:0]       ALUControlOpcode,
   input  logic [WIDTH-1:0] operandA,
   input  logic [WIDTH-1:0] operandB,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic             stallReq,
   output logic [WIDTH-1:0] hiOut,
   output logic [WIDTH-1:0] loOut,
   output logic [WIDTH-1:0] mfResult
);
   localparam logic [5:0] OP_MULT  = 6'b011000;
   localparam logic [5:0] OP_MULTU = 6'b011001;
   localparam logic [5:0] OP_DIV   = 6'b011010;
   localparam logic [5:0] OP_DIVU  = 6'b011011;
   localparam logic [5:0] OP_MFHI  = 6'b010000;
   localparam logic [5:0] OP_MTHI  = 6'b010001;
   localparam logic [5:0] OP_MFLO  = 6'b010010;
   localparam logic [5:0] OP_MTLO  = 6'b010011;
   localparam logic [5:0] LAST     = 6'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

   state_e               state_q;
   logic [5:0]           cnt_q;
   logic                 is_mul_q, neg_res_q, neg_rem_q, done_q;
   logic [WIDTH-1:0]     opa_q, opb_q, hi_q, lo_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [WIDTH:0]       rem_q;

   logic                 is_mul, is_div, is_sgn, is_md, is_mf, is_mt;
   logic                 a_neg, b_neg;
   logic [WIDTH-1:0]     abs_a, abs_b;

   always_comb begin
      is_mul = (ALUControlOpcode == OP_MULT) || (ALUControlOpcode == OP_MULTU);
      is_div = (ALUControlOpcode == OP_DIV)  || (ALUControlOpcode == OP_DIVU);
      is_sgn = (ALUControlOpcode == OP_MULT) || (ALUControlOpcode == OP_DIV);
      is_md  = is_mul || is_div;
      is_mf  = (ALUControlOpcode == OP_MFHI) || (ALUControlOpcode == OP_MFLO);
      is_mt  = (ALUControlOpcode == OP_MTHI) || (ALUControlOpcode == OP_MTLO);
      a_neg  = is_sgn && operandA[WIDTH-1];
      b_neg  = is_sgn && operandB[WIDTH-1];
      abs_a  = a_neg ? -operandA : operandA;
      abs_b  = b_neg ? -operandB : operandB;
   end

   // Multiply: low half of acc holds the remaining multiplier bits, high half
   // accumulates; the carry of the add is shifted back in at the top.
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   // Divide: low half of acc holds dividend bits being shifted out and
   // quotient bits being shifted in.
   logic [WIDTH:0]       div_shift, div_diff, rem_next;
   logic                 qbit;
   logic [WIDTH-1:0]     quot_next;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opb_q};
      qbit      = ~div_diff[WIDTH];
      rem_next  = qbit ? div_diff : div_shift;
      quot_next = {acc_q[WIDTH-2:0], qbit};
   end

   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quot_fix, rem_fix;

   always_comb begin
      prod_fix = neg_res_q ? -acc_q : acc_q;
      quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         is_mul_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         done_q    <= 1'b0;
         opa_q     <= '0;
         opb_q     <= '0;
         acc_q     <= '0;
         rem_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (opValid && is_md) begin
                  if (is_div && operandB == '0) begin
                     hi_q   <= operandA;
                     lo_q   <= '1;
                     done_q <= 1'b1;
                  end else begin
                     state_q   <= CALC;
                     cnt_q     <= '0;
                     is_mul_q  <= is_mul;
                     neg_res_q <= a_neg ^ b_neg;
                     neg_rem_q <= a_neg;
                     opa_q     <= abs_a;
                     opb_q     <= abs_b;
                     acc_q     <= {{WIDTH{1'b0}}, (is_mul ? abs_b : abs_a)};
                     rem_q     <= '0;
                  end
               end else if (opValid && ALUControlOpcode == OP_MTHI) begin
                  hi_q <= operandA;
               end else if (opValid && ALUControlOpcode == OP_MTLO) begin
                  lo_q <= operandA;
               end
            end
            CALC: begin
               if (cancel) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  acc_q <= is_mul_q ? mul_next : {acc_q[2*WIDTH-1:WIDTH], quot_next};
                  rem_q <= is_mul_q ? rem_q : rem_next;
                  if (cnt_q == LAST) begin
                     state_q <= FIX;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 6'd1;
                  end
               end
            end
            FIX: begin
               state_q <= IDLE;
               if (!cancel) begin
                  hi_q   <= is_mul_q ? prod_fix[2*WIDTH-1:WIDTH] : rem_fix;
                  lo_q   <= is_mul_q ? prod_fix[WIDTH-1:0] : quot_fix;
                  done_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      mfResult = '0;
      if (ALUControlOpcode == OP_MFHI)      mfResult = hi_q;
      else if (ALUControlOpcode == OP_MFLO) mfResult = lo_q;
   end

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign hiOut    = hi_q;
   assign loOut    = lo_q;
   assign stallReq = opValid && busy && (is_md || is_mf || is_mt);
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: issued mult/div results are queued and
// checked by a monitor on every done pulse; directed checks cover the rest.
module tb_mult_div_unit;
   localparam logic [5:0] MULT  = 6'b011000, MULTU = 6'b011001;
   localparam logic [5:0] DIV   = 6'b011010, DIVU  = 6'b011011;
   localparam logic [5:0] MFHI  = 6'b010000, MFLO  = 6'b010010;
   localparam logic [5:0] MTHI  = 6'b010001, MTLO  = 6'b010011;
   localparam logic [5:0] ADD   = 6'b100000;

   logic        clk, rst_n, opValid, cancel;
   logic [5:0]  op;
   logic [31:0] a, b;
   logic        busy, done, stallReq;
   logic [31:0] hiOut, loOut, mfResult;

   int total = 0;
   int bad = 0;
   logic [63:0] sbq[$];
   logic [31:0] exp_hi, exp_lo;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .opValid(opValid), .ALUControlOpcode(op),
      .operandA(a), .operandB(b), .cancel(cancel), .busy(busy), .done(done),
      .stallReq(stallReq), .hiOut(hiOut), .loOut(loOut), .mfResult(mfResult)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued result.
   initial forever begin
      @(negedge clk);
      if (rst_n && done === 1'b1) begin
         if (sbq.size() == 0) chk("done_without_issue", 64'(sbq.size()), 64'd1);
         else chk("hilo_result", {hiOut, loOut}, sbq.pop_front());
      end
   end

   task automatic run_op(input string name, input logic [5:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] ehi,
                         input logic [31:0] elo, input int ebusy);
      int bc = 0;
      int dn = 0;
      sbq.push_back({ehi, elo});
      op = o; a = x; b = y; opValid = 1'b1;
      @(posedge clk); #1;
      opValid = 1'b0;
      for (int i = 0; i < 40 && dn == 0; i++) begin
         @(negedge clk);
         if (busy) bc++;
         if (done) dn = 1;
      end
      chk({name, "_done_seen"}, 64'(dn), 64'd1);
      chk({name, "_busy_cycles"}, 64'(bc), 64'(ebusy));
      @(posedge clk); #1;
      chk({name, "_done_single"}, 64'(done), 64'd0);
      exp_hi = ehi; exp_lo = elo;
   endtask

   initial begin
      int sbad, dn, dseen;
      rst_n = 1'b0; opValid = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
      #12;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hilo", {hiOut, loOut}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
      run_op("mult_neg",  MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 33);
      run_op("div_neg",   DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33);
      run_op("divu",      DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        33);
      run_op("div_negb",  DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33);
      run_op("mult_ext",  MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 33);
      run_op("div_ovf",   DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
      run_op("divu_zero", DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 0);
      run_op("div_zero",  DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 0);

      // MFHI waiting on an in-flight MULT, with an ADD slipped in first.
      sbq.push_back({32'd3, 32'd0});
      op = MULT; a = 32'h00010000; b = 32'h00030000; opValid = 1'b1;
      @(posedge clk); #1;
      op = ADD; #1;
      chk("add_busy", 64'(busy), 64'd1);
      chk("add_no_stall", 64'(stallReq), 64'd0);
      @(posedge clk); #1;
      op = MFHI;
      sbad = 0; dn = 0;
      for (int i = 0; i < 40 && dn == 0; i++) begin
         @(negedge clk);
         if (done) begin
            dn = 1;
            chk("mfhi_done_stall", 64'(stallReq), 64'd0);
            chk("mfhi_new_hi", 64'(mfResult), 64'd3);
         end else if (stallReq !== 1'b1) sbad++;
      end
      chk("mfhi_stall_held", 64'(sbad), 64'd0);
      chk("mfhi_done_seen", 64'(dn), 64'd1);
      @(posedge clk); #1;
      opValid = 1'b0;
      exp_hi = 32'd3; exp_lo = 32'd0;

      // HI/LO moves
      op = MTLO; a = 32'hCAFEF00D; opValid = 1'b1;
      @(posedge clk); #1;
      op = MFLO; #1;
      chk("mtlo_lo", 64'(loOut), 64'hCAFEF00D);
      chk("mtlo_hi_kept", 64'(hiOut), 64'(exp_hi));
      chk("mflo_result", 64'(mfResult), 64'hCAFEF00D);
      chk("mtlo_no_busy", 64'({busy, done, stallReq}), 64'd0);
      op = MTHI; a = 32'h12345678;
      @(posedge clk); #1;
      op = MFHI; #1;
      chk("mthi_hi", 64'(hiOut), 64'h12345678);
      chk("mfhi_result", 64'(mfResult), 64'h12345678);
      op = ADD; #1;
      chk("mf_other_zero", 64'(mfResult), 64'd0);
      opValid = 1'b0;
      exp_hi = 32'h12345678; exp_lo = 32'hCAFEF00D;

      // Cancel during CALC iteration 10
      op = DIVU; a = 32'd100; b = 32'd7; opValid = 1'b1;
      @(posedge clk); #1;
      opValid = 1'b0;
      repeat (10) @(posedge clk);
      #1 cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      chk("cancel_idle", 64'(busy), 64'd0);
      dseen = 0;
      repeat (40) begin @(negedge clk); if (done) dseen++; end
      chk("cancel_no_done", 64'(dseen), 64'd0);
      chk("cancel_hilo_kept", {hiOut, loOut}, {exp_hi, exp_lo});

      // Reset during CALC iteration 20
      @(posedge clk); #1;
      op = MULTU; a = 32'd9; b = 32'd9; opValid = 1'b1;
      @(posedge clk); #1;
      opValid = 1'b0;
      repeat (20) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_hilo", {hiOut, loOut}, 64'd0);
      #1 rst_n = 1'b1;
      dseen = 0;
      repeat (40) begin @(negedge clk); if (done) dseen++; end
      chk("midrst_no_done", 64'(dseen), 64'd0);
      @(posedge clk); #1;
      run_op("post_rst_divu", DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 33);

      repeat (3) @(posedge clk);
      chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
